// File: rtl/if_id_buf_pkg.sv
// Shared defines (XLEN, INST_LEN, PC_RESET, INST_NOP) and FIFO entry type for the IF/ID buffer.
`ifndef XLEN
`define XLEN 64
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef PC_RESET
`define PC_RESET `XLEN'h8000_0000
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

package if_id_buf_pkg;

  localparam int XLEN     = `XLEN;
  localparam int INST_LEN = `INST_LEN;

  localparam logic [XLEN-1:0]     PC_RESET_VAL = `PC_RESET;
  localparam logic [INST_LEN-1:0] INST_NOP_VAL = `INST_NOP;

  localparam logic [1:0] DEPTH = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [INST_LEN-1:0] instr;
  } ifid_entry_t;

  localparam ifid_entry_t ENTRY_RESET = '{pc: PC_RESET_VAL, instr: INST_NOP_VAL};

endpackage

// File: rtl/ifid_stall_cnt.sv
// Saturating 32-bit counter of fetch cycles held off by a full IF/ID buffer.
module ifid_stall_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   output logic [31:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 32'd0;
      end else if (stall && (cnt != 32'hFFFF_FFFF)) begin
         cnt <= cnt + 32'd1;
      end
   end

endmodule

// File: rtl/if_id_buf.sv
// Two-entry {pc, instr} FIFO between fetch and decode, flushable on redirect.
// Define IFID_STALL_CNT_EN to add the stall_cnt_o fetch-stall counter.
import if_id_buf_pkg::*;

module if_id_buf (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid_i,
   input  logic [XLEN-1:0]     in_pc_i,
   input  logic [INST_LEN-1:0] in_instr_i,
   output logic                in_ready_o,
   output logic                out_valid_o,
   output logic [XLEN-1:0]     out_pc_o,
   output logic [INST_LEN-1:0] out_instr_o,
   input  logic                out_ready_i,
`ifdef IFID_STALL_CNT_EN
   output logic [31:0]         stall_cnt_o,
`endif
   input  logic                flush_i
);

   ifid_entry_t mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;
   ifid_entry_t head;

   // Ready and valid come only from registered count (plus flush), never from the peer's handshake.
   assign in_ready_o  = (count != DEPTH);
   assign out_valid_o = (count != 2'd0) && !flush_i;

   assign push = in_valid_i && in_ready_o && !flush_i;
   assign pop  = out_valid_o && out_ready_i;

   assign head        = mem[rd_ptr];
   assign out_pc_o    = head.pc;
   assign out_instr_o = out_valid_o ? head.instr : INST_NOP_VAL;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         mem[0] <= ENTRY_RESET;
         mem[1] <= ENTRY_RESET;
      end else if (flush_i) begin
         count  <= 2'd0;
         rd_ptr <= wr_ptr;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{pc: in_pc_i, instr: in_instr_i};
            wr_ptr      <= !wr_ptr;
         end
         if (pop) begin
            rd_ptr <= !rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`ifdef IFID_STALL_CNT_EN
   ifid_stall_cnt u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .stall (in_valid_i && !in_ready_o),
      .cnt   (stall_cnt_o)
   );
`endif

endmodule
